// File: rtl/stack_sequencer_pkg.sv
// Shared opcode and state encodings for the stack instruction sequencer.
package stack_sequencer_pkg;

    localparam int unsigned DataWDefault = 8;
    localparam int unsigned DepthDefault = 8;

    typedef enum logic [2:0] {
        OpNop  = 3'b000,
        OpPush = 3'b001,
        OpPop  = 3'b010,
        OpTop  = 3'b011,
        OpAdd  = 3'b100,
        OpSub  = 3'b101,
        OpAnd  = 3'b110,
        OpDup  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StTosA,
        StCapA,
        StTosB,
        StCapB,
        StPush
    } state_e;

    function automatic logic op_is_binary(op_e op);
        return (op == OpAdd) || (op == OpSub) || (op == OpAnd);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ADD/SUB/AND on the two operands popped from the stack.
module stack_alu
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] a_i,
    input  op_e               op_i,
    output logic [DATA_W-1:0] res_o
);

    // b_i is the entry below the old top, so SUB yields b - a; all results wrap.
    always_comb begin
        res_o = '0;
        case (op_i)
            OpAdd:   res_o = b_i + a_i;
            OpSub:   res_o = b_i - a_i;
            OpAnd:   res_o = b_i & a_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Expands one stack instruction at a time into tos/pop/push strobes for an external Stack.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = DepthDefault
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [DATA_W-1:0]          cmd_imm,
    output logic                       result_valid,
    output logic [DATA_W-1:0]          result_data,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DATA_W-1:0]          stk_data_in,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic                       stk_tos,
    input  logic [DATA_W-1:0]          stk_data_out
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] OneC   = CntW'(1);
    localparam logic [CntW-1:0] TwoC   = CntW'(2);

    state_e              state_q;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q;
    logic [CntW-1:0]     count_q;
    logic                result_valid_q;
    logic [DATA_W-1:0]   result_data_q;
    logic                err_q;
    logic [DATA_W-1:0]   stk_data_in_q;
    logic                stk_push_q;
    logic                stk_pop_q;
    logic                stk_tos_q;

    op_e                 cmd_op_e;
    logic                legal;
    logic [DATA_W-1:0]   alu_res;

    assign cmd_op_e = op_e'(cmd_op);

    always_comb begin
        legal = 1'b0;
        case (cmd_op_e)
            OpNop:                legal = 1'b1;
            OpPush:               legal = (count_q < DepthC);
            OpPop, OpTop:         legal = (count_q >= OneC);
            OpDup:                legal = (count_q >= OneC) && (count_q < DepthC);
            OpAdd, OpSub, OpAnd:  legal = (count_q >= TwoC);
            default:              legal = 1'b0;
        endcase
    end

    // B is consumed straight off the Stack read port during CAP_B, so it needs no register.
    stack_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .b_i   (stk_data_out),
        .a_i   (a_q),
        .op_i  (op_q),
        .res_o (alu_res)
    );

    // Strobes are registered: the value set on a transition is what the entered state drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= OpNop;
            a_q            <= '0;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            err_q          <= 1'b0;
            stk_data_in_q  <= '0;
            stk_push_q     <= 1'b0;
            stk_pop_q      <= 1'b0;
            stk_tos_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            stk_data_in_q  <= '0;
            stk_push_q     <= 1'b0;
            stk_pop_q      <= 1'b0;
            stk_tos_q      <= 1'b0;

            if (stk_push_q) begin
                count_q <= count_q + OneC;
            end else if (stk_pop_q) begin
                count_q <= count_q - OneC;
            end

            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op_e;
                        if (!legal) begin
                            err_q <= 1'b1;
                        end else if (cmd_op_e == OpPush) begin
                            state_q       <= StPush;
                            stk_push_q    <= 1'b1;
                            stk_data_in_q <= cmd_imm;
                        end else if (cmd_op_e != OpNop) begin
                            state_q   <= StTosA;
                            stk_tos_q <= 1'b1;
                        end
                    end
                end
                StTosA: begin
                    state_q   <= StCapA;
                    stk_pop_q <= !((op_q == OpTop) || (op_q == OpDup));
                end
                StCapA: begin
                    a_q <= stk_data_out;
                    if (op_q == OpDup) begin
                        state_q       <= StPush;
                        stk_push_q    <= 1'b1;
                        stk_data_in_q <= stk_data_out;
                    end else if (op_is_binary(op_q)) begin
                        state_q   <= StTosB;
                        stk_tos_q <= 1'b1;
                    end else begin
                        state_q        <= StIdle;
                        result_valid_q <= 1'b1;
                        result_data_q  <= stk_data_out;
                    end
                end
                StTosB: begin
                    state_q   <= StCapB;
                    stk_pop_q <= 1'b1;
                end
                StCapB: begin
                    state_q       <= StPush;
                    stk_push_q    <= 1'b1;
                    stk_data_in_q <= alu_res;
                end
                StPush: begin
                    state_q        <= StIdle;
                    result_valid_q <= 1'b1;
                    result_data_q  <= stk_data_in_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready    = (state_q == StIdle);
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign err          = err_q;
    assign count        = count_q;
    assign stk_data_in  = stk_data_in_q;
    assign stk_push     = stk_push_q;
    assign stk_pop      = stk_pop_q;
    assign stk_tos      = stk_tos_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer with a behavioural Stack model on its strobe ports.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_imm;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic          err;
    logic [CW-1:0] count;
    logic [DW-1:0] stk_data_in;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_tos;
    logic [DW-1:0] stk_data_out;

    always #5 clk = ~clk;

    stack_sequencer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_imm      (cmd_imm),
        .result_valid (result_valid),
        .result_data  (result_data),
        .err          (err),
        .count        (count),
        .stk_data_in  (stk_data_in),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_tos      (stk_tos),
        .stk_data_out (stk_data_out)
    );

    // Stack model: tos in cycle N presents the top on data_out in cycle N+1.
    logic [DW-1:0] mem [DEPTH];
    int            sp;
    logic [DW-1:0] dout;
    assign stk_data_out = dout;

    always @(posedge clk) begin
        if (rst) begin
            sp   <= 0;
            dout <= '0;
        end else begin
            if (stk_push && sp < DEPTH) begin
                mem[sp] <= stk_data_in;
                sp      <= sp + 1;
            end else if (stk_pop && sp > 0) begin
                sp <= sp - 1;
            end
            if (stk_tos && sp > 0) dout <= mem[sp-1];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          is_err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    function automatic void exp_res(input logic [DW-1:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        sb.push_back(e);
    endfunction

    function automatic void exp_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && (result_valid || err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: result_valid=%0b err=%0b data=0x%0h, required none",
                         result_valid, err, result_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_is_err", {31'd0, err}, {31'd0, e.is_err});
                check("sb_result_valid", {31'd0, result_valid}, {31'd0, !e.is_err});
                if (!e.is_err) check("sb_result_data", {24'd0, result_data}, {24'd0, e.data});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [DW-1:0] imm);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_imm   = '0;
    endtask

    // Leaves the bench at the first negedge with cmd_ready high after an accepted command.
    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [DW-1:0] imm, input logic [DW-1:0] res);
        exp_res(res);
        issue(op, imm);
        wait_idle();
    endtask

    task automatic trace(input string name, input logic [2:0] op, input logic [DW-1:0] imm,
                         input int n, input logic [14:0] pats, input logic [DW-1:0] pval,
                         input logic [DW-1:0] res);
        logic [2:0] p;
        exp_res(res);
        issue(op, imm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p = pats[3*i +: 3];
            check({name, "_strobes"}, {29'd0, stk_tos, stk_pop, stk_push}, {29'd0, p});
            check({name, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
            if (p[0]) check({name, "_push_data"}, {24'd0, stk_data_in}, {24'd0, pval});
        end
        @(negedge clk);
        check({name, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic reject(input string name, input logic [2:0] op, input logic [CW-1:0] cnt);
        exp_err();
        issue(op, 8'h99);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({name, "_no_strobe"}, {29'd0, stk_tos, stk_pop, stk_push}, 32'd0);
            check({name, "_ready"}, {31'd0, cmd_ready}, 32'd1);
            check({name, "_count"}, {{(32-CW){1'b0}}, count}, {{(32-CW){1'b0}}, cnt});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_imm   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check("rst_rvalid", {31'd0, result_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {24'd0, result_data}, 32'd0);
        check("rst_strobes", {29'd0, stk_tos, stk_pop, stk_push}, 32'd0);
        check("rst_data_in", {24'd0, stk_data_in}, 32'd0);

        trace("push0c", OpPush, 8'h0C, 1, 15'b001, 8'h0C, 8'h0C);
        trace("push05", OpPush, 8'h05, 1, 15'b001, 8'h05, 8'h05);
        check("count_after_2push", {{(32-CW){1'b0}}, count}, 32'd2);

        trace("sub", OpSub, 8'h00, 5, {3'b001, 3'b010, 3'b100, 3'b010, 3'b100}, 8'h07, 8'h07);
        check("count_after_sub", {{(32-CW){1'b0}}, count}, 32'd1);
        cmd(OpPop, 8'h00, 8'h07);
        check("count_after_pop", {{(32-CW){1'b0}}, count}, 32'd0);

        cmd(OpPush, 8'hF0, 8'hF0);
        cmd(OpPush, 8'h20, 8'h20);
        trace("add_wrap", OpAdd, 8'h00, 5, {3'b001, 3'b010, 3'b100, 3'b010, 3'b100}, 8'h10, 8'h10);
        cmd(OpPush, 8'h01, 8'h01);
        cmd(OpPush, 8'h02, 8'h02);
        cmd(OpSub, 8'h00, 8'hFF);
        check("count_after_sub_wrap", {{(32-CW){1'b0}}, count}, 32'd2);
        cmd(OpPop, 8'h00, 8'hFF);
        cmd(OpPop, 8'h00, 8'h10);
        exp_res(8'h0F);
        issue(OpPush, 8'h0F);
        exp_res(8'h0F);
        issue(OpPush, 8'h0F);
        cmd(OpAnd, 8'h00, 8'h0F);
        cmd(OpPop, 8'h00, 8'h0F);

        reject("pop_empty", OpPop, 4'd0);
        reject("add_empty", OpAdd, 4'd0);

        for (int i = 0; i < DEPTH; i++) cmd(OpPush, 8'h40 + 8'(i), 8'h40 + 8'(i));
        check("count_full", {{(32-CW){1'b0}}, count}, 32'd8);
        reject("push_full", OpPush, 4'd8);
        reject("dup_full", OpDup, 4'd8);
        for (int i = DEPTH - 1; i >= 0; i--) cmd(OpPop, 8'h00, 8'h40 + 8'(i));
        check("count_drained", {{(32-CW){1'b0}}, count}, 32'd0);

        cmd(OpPush, 8'h3A, 8'h3A);
        trace("top", OpTop, 8'h00, 2, {9'd0, 3'b000, 3'b100}, 8'h00, 8'h3A);
        check("count_after_top", {{(32-CW){1'b0}}, count}, 32'd1);
        trace("dup", OpDup, 8'h00, 3, {6'd0, 3'b001, 3'b000, 3'b100}, 8'h3A, 8'h3A);
        check("count_after_dup", {{(32-CW){1'b0}}, count}, 32'd2);
        cmd(OpPop, 8'h00, 8'h3A);
        check("count_after_dup_pop", {{(32-CW){1'b0}}, count}, 32'd1);

        cmd(OpPush, 8'h11, 8'h11);
        issue(OpAdd, 8'h00);
        repeat (3) @(negedge clk);
        check("abort_in_tos_b", {29'd0, stk_tos, stk_pop, stk_push}, 32'b100);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check("abort_strobes", {29'd0, stk_tos, stk_pop, stk_push}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_abort_push", {31'd0, stk_push}, 32'd0);
        check("post_abort_count", {{(32-CW){1'b0}}, count}, 32'd0);

        cmd(OpPush, 8'h55, 8'h55);
        check("count_post_abort_push", {{(32-CW){1'b0}}, count}, 32'd1);
        issue(OpNop, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("nop_quiet", {29'd0, stk_tos, stk_pop, stk_push}, 32'd0);
            check("nop_ready", {31'd0, cmd_ready}, 32'd1);
        end
        check("nop_count", {{(32-CW){1'b0}}, count}, 32'd1);
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
